// File: rtl/frame_ring_pkg.sv
// Shared constants and helpers for the frame ring address generator.
package frame_ring_pkg;

  localparam int unsigned DEF_FRAME_BYTES = 3_686_400;
  localparam int unsigned DEF_BEAT_BYTES  = 4;
  localparam int unsigned DEF_NUM_BUFS    = 3;
  localparam int unsigned MAX_ADDR_W      = 64;

  // Width of an index able to hold 0..n-1 (at least one bit).
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  // (idx - off) mod n without ever forming a negative intermediate.
  function automatic int unsigned ring_sub(input int unsigned idx,
                                           input int unsigned off,
                                           input int unsigned n);
    return (idx + n - (off % n)) % n;
  endfunction

  // Byte address of buffer idx; callers truncate to their address width.
  function automatic logic [MAX_ADDR_W-1:0] buf_base(input logic [MAX_ADDR_W-1:0] base,
                                                     input logic [MAX_ADDR_W-1:0] frame_bytes,
                                                     input int unsigned idx);
    return base + MAX_ADDR_W'(idx) * frame_bytes;
  endfunction

endpackage

// File: rtl/ring_idx_ctr.sv
// Mod-NUM ring index counter with lagged-offset lookups of its next value.
module ring_idx_ctr
  import frame_ring_pkg::*;
#(
  parameter int unsigned NUM     = 3,
  parameter int unsigned W       = 2,
  parameter int unsigned NUM_OFF = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         advance,
  output logic [W-1:0] idx,
  output logic [W-1:0] idx_next_c,
  output logic [W-1:0] off_idx_c [NUM_OFF]
);

  function automatic logic [W-1:0] off_lookup(input logic [W-1:0] cur, input int unsigned off);
    return W'(ring_sub(32'(cur), off, NUM));
  endfunction

  // Next index: step by one with wrap at NUM-1.
  always_comb begin
    idx_next_c = idx;
    if (advance) begin
      idx_next_c = (idx == W'(NUM - 1)) ? '0 : idx + W'(1);
    end
  end

  // Offset k maps to (next - 1 - k) mod NUM.
  always_comb begin
    for (int k = 0; k < NUM_OFF; k++) begin
      off_idx_c[k] = off_lookup(idx_next_c, 32'(k + 1));
    end
  end

  // Index register.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
    end else begin
      idx <= idx_next_c;
    end
  end

endmodule

// File: rtl/frame_ring_addr_gen.sv
// N-buffer frame ring address generator: one write stream, NUM_RD lagged
// read streams. Define FRAME_RING_LAST_CHECK_EN to build the frame-length
// checker driving last_err; otherwise last_err is tied low.
module frame_ring_addr_gen
  import frame_ring_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int unsigned       FRAME_BYTES = DEF_FRAME_BYTES,
  parameter int unsigned       BEAT_BYTES  = DEF_BEAT_BYTES,
  parameter int unsigned       NUM_BUFS    = DEF_NUM_BUFS,
  parameter int unsigned       NUM_RD      = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic                        last,
  input  logic                        drop,
  output logic [ADDR_W-1:0]           write_addr,
  output logic [ADDR_W-1:0]           read_addr [NUM_RD],
  output logic [NUM_RD-1:0]           rd_valid,
  output logic [$clog2(NUM_BUFS)-1:0] wr_idx,
  output logic                        last_err
);

  localparam int unsigned IW = idx_w(NUM_BUFS);
  localparam int unsigned CW = $clog2(NUM_RD + 1);

  typedef logic [IW-1:0] idx_t;

  if (NUM_BUFS < 2 || NUM_BUFS > 8) begin : g_bad_num_bufs
    $error("frame_ring_addr_gen: NUM_BUFS must be 2..8");
  end
  if (NUM_RD < 1 || NUM_RD > NUM_BUFS - 1) begin : g_bad_num_rd
    $error("frame_ring_addr_gen: NUM_RD must be 1..NUM_BUFS-1");
  end
  if (BEAT_BYTES == 0 || (FRAME_BYTES % BEAT_BYTES) != 0) begin : g_bad_beat
    $error("frame_ring_addr_gen: FRAME_BYTES must be a multiple of BEAT_BYTES");
  end
  if (ADDR_W > MAX_ADDR_W) begin : g_bad_addr_w
    $error("frame_ring_addr_gen: ADDR_W too wide");
  end

  function automatic logic [ADDR_W-1:0] base_of(input int unsigned idx);
    return ADDR_W'(buf_base(MAX_ADDR_W'(BASE_ADDR), MAX_ADDR_W'(FRAME_BYTES), idx));
  endfunction

  logic              advance;
  idx_t              idx_next;
  idx_t              off_idx [NUM_RD];
  logic [CW-1:0]     frames;
  logic [CW-1:0]     frames_nxt;
  logic [NUM_RD-1:0] valid_nxt;

  assign advance = enable && last && !drop;

  ring_idx_ctr #(
    .NUM     (NUM_BUFS),
    .W       (IW),
    .NUM_OFF (NUM_RD)
  ) u_wr_idx (
    .clk        (clk),
    .rst        (rst),
    .advance    (advance),
    .idx        (wr_idx),
    .idx_next_c (idx_next),
    .off_idx_c  (off_idx)
  );

  // Saturating completed-frame count and the validity it implies.
  always_comb begin
    frames_nxt = frames;
    if (frames != CW'(NUM_RD)) begin
      frames_nxt = frames + CW'(1);
    end
    valid_nxt = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      valid_nxt[k] = (32'(frames_nxt) >= 32'(k + 1));
    end
  end

  // Address streams: step per beat, reload buffer bases on any last.
  always_ff @(posedge clk) begin
    if (rst) begin
      write_addr <= base_of(0);
      for (int k = 0; k < NUM_RD; k++) begin
        read_addr[k] <= base_of(ring_sub(0, 32'(k + 1), NUM_BUFS));
      end
    end else if (enable) begin
      if (last) begin
        write_addr <= base_of(32'(idx_next));
        for (int k = 0; k < NUM_RD; k++) begin
          read_addr[k] <= base_of(32'(off_idx[k]));
        end
      end else begin
        write_addr <= write_addr + ADDR_W'(BEAT_BYTES);
        for (int k = 0; k < NUM_RD; k++) begin
          read_addr[k] <= read_addr[k] + ADDR_W'(BEAT_BYTES);
        end
      end
    end
  end

  // Completed-frame tracking; dropped frames leave it untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      frames   <= '0;
      rd_valid <= '0;
    end else if (advance) begin
      frames   <= frames_nxt;
      rd_valid <= valid_nxt;
    end
  end

`ifdef FRAME_RING_LAST_CHECK_EN
  localparam int unsigned BEATS = FRAME_BYTES / BEAT_BYTES;
  localparam int unsigned BW    = idx_w(BEATS);
  localparam logic [BW-1:0] TERM = BW'(BEATS - 1);

  logic [BW-1:0] beat_cnt;

  // Beat counter flags early last and beats past the terminal count.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt <= '0;
      last_err <= 1'b0;
    end else begin
      last_err <= 1'b0;
      if (enable) begin
        if (last) begin
          last_err <= (beat_cnt != TERM);
          beat_cnt <= '0;
        end else if (beat_cnt == TERM) begin
          last_err <= 1'b1;
        end else begin
          beat_cnt <= beat_cnt + BW'(1);
        end
      end
    end
  end
`else
  assign last_err = 1'b0;
`endif

endmodule

// File: tb/tb_frame_ring_addr_gen.sv
// Directed bench for frame_ring_addr_gen with a frame/offset reference model.
module tb_frame_ring_addr_gen;

  localparam int unsigned FB   = 16;
  localparam int unsigned BB   = 4;
  localparam int unsigned NB   = 3;
  localparam int unsigned NR   = 2;
  localparam int unsigned TERM = FB / BB - 1;
`ifdef FRAME_RING_LAST_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        last = 1'b0;
  logic        drop = 1'b0;
  logic [31:0] write_addr;
  logic [31:0] read_addr [NR];
  logic [1:0]  rd_valid;
  logic [1:0]  wr_idx;
  logic        last_err;

  int total = 0;
  int bad   = 0;

  // Model state: buffer being written, byte offset into it, frames done.
  int unsigned m_idx = 0;
  int unsigned m_off = 0;
  int unsigned m_frames = 0;
  int unsigned m_beats = 0;
  bit          m_err = 1'b0;
  bit          model_on = 1'b0;

  frame_ring_addr_gen #(
    .ADDR_W      (32),
    .BASE_ADDR   (32'h0),
    .FRAME_BYTES (FB),
    .BEAT_BYTES  (BB),
    .NUM_BUFS    (NB),
    .NUM_RD      (NR)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .last       (last),
    .drop       (drop),
    .write_addr (write_addr),
    .read_addr  (read_addr),
    .rd_valid   (rd_valid),
    .wr_idx     (wr_idx),
    .last_err   (last_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int unsigned exp_rd(input int unsigned k);
    return ((m_idx + NB - 1 - k) % NB) * FB + m_off;
  endfunction

  // Reference model advances on each clock edge from the sampled inputs.
  always @(posedge clk) begin
    m_err = 1'b0;
    if (rst) begin
      m_idx = 0; m_off = 0; m_frames = 0; m_beats = 0;
    end else if (enable) begin
      if (last) begin
        m_err   = CHK && (m_beats != TERM);
        m_beats = 0;
        m_off   = 0;
        if (!drop) begin
          m_idx = (m_idx + 1) % NB;
          if (m_frames < NR) m_frames++;
        end
      end else begin
        if (m_beats == TERM) m_err = CHK;
        else m_beats++;
        m_off += BB;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (model_on) begin
      check("m_write_addr", write_addr, m_idx * FB + m_off);
      for (int k = 0; k < NR; k++) begin
        check($sformatf("m_read_addr%0d", k), read_addr[k], exp_rd(k));
      end
      check("m_rd_valid", rd_valid, {62'd0, m_frames >= 2, m_frames >= 1});
      check("m_wr_idx", wr_idx, m_idx);
      check("m_last_err", last_err, m_err);
    end
  end

  task automatic step(input bit en, input bit l, input bit d, input bit r);
    enable = en; last = l; drop = d; rst = r;
    @(negedge clk);
  endtask

  task automatic frame();
    repeat (3) step(1, 0, 0, 0);
    step(1, 1, 0, 0);
  endtask

  initial begin
    step(0, 0, 0, 1);
    model_on = 1'b1;
    step(0, 0, 0, 1);
    check("rst_wa", write_addr, 0);
    check("rst_ra0", read_addr[0], 32);
    check("rst_ra1", read_addr[1], 16);
    check("rst_valid", rd_valid, 0);
    check("rst_idx", wr_idx, 0);

    // Frame 1
    repeat (3) step(1, 0, 0, 0);
    check("f1_wa12", write_addr, 12);
    check("f1_ra0_44", read_addr[0], 44);
    step(1, 1, 0, 0);
    check("f1_wa", write_addr, 16);
    check("f1_ra0", read_addr[0], 0);
    check("f1_ra1", read_addr[1], 32);
    check("f1_valid", rd_valid, 2'b01);
    check("f1_idx", wr_idx, 1);

    // Frames 2 and 3: ring wraps
    frame();
    check("f2_idx", wr_idx, 2);
    check("f2_valid", rd_valid, 2'b11);
    frame();
    check("f3_idx", wr_idx, 0);
    check("f3_wa", write_addr, 0);
    check("f3_ra0", read_addr[0], 32);
    check("f3_ra1", read_addr[1], 16);
    check("f3_valid", rd_valid, 2'b11);

    // Idle gap: last/drop ignored without enable
    repeat (3) step(0, 1, 1, 0);
    check("idle_wa", write_addr, 0);
    check("idle_idx", wr_idx, 0);

    // Drop inside buffer 1
    frame();
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    check("drop_pre_wa", write_addr, 24);
    step(1, 1, 1, 0);
    check("drop_wa", write_addr, 16);
    check("drop_idx", wr_idx, 1);
    check("drop_valid", rd_valid, 2'b11);
    check("drop_ra0", read_addr[0], 0);

    // Early last on beat 2
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    check("early_err", last_err, CHK);
    check("early_idx", wr_idx, 2);
    check("early_wa", write_addr, 32);
    step(0, 0, 0, 0);
    check("early_err_clr", last_err, 0);

    // Reset mid-frame at write_addr=8
    frame();
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    check("mid_pre_wa", write_addr, 8);
    step(1, 0, 0, 1);
    check("mid_wa", write_addr, 0);
    check("mid_ra0", read_addr[0], 32);
    check("mid_ra1", read_addr[1], 16);
    check("mid_valid", rd_valid, 0);
    check("mid_idx", wr_idx, 0);

    // Late last: five beats without last
    repeat (4) step(1, 0, 0, 0);
    check("late_wa16", write_addr, 16);
    check("late_err", last_err, CHK);
    step(1, 0, 0, 0);
    check("late_wa20", write_addr, 20);
    step(1, 1, 0, 0);
    check("late_last_ok", last_err, 0);
    check("late_idx", wr_idx, 1);
    check("late_valid", rd_valid, 2'b01);
    check("late_wa", write_addr, 16);

    step(0, 0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
